accum_ctrl: RTL and testbench

ACCUM_CTRL -- requirements
Module: accum_ctrl

---
 rtl/accum_pkg.sv | 18 +
 rtl/accum_ctrl_credit_cnt.sv | 26 ++
 rtl/accum_ctrl.sv | 122 ++++++++++++
 tb/tb_accum_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared state encoding and default sizing for the accumulator controller.
package accum_pkg;

  localparam int DATAW_D   = 32;
  localparam int DEPTH_D   = 512;
  localparam int ADDRW_D   = 9;
  localparam int SUBW_D    = 8;
  localparam int HAZ_D     = 4;
  localparam int CREDITS_D = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/accum_ctrl_credit_cnt.sv
// Downstream result-queue credit counter; saturates at 0 and CREDITS.
module credit_cnt import accum_pkg::*; #(
  parameter int CREDITS = CREDITS_D
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic inc,
  output logic avail
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] credit;

  // A take and a return in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    credit <= FULL;
    else if (dec && !inc && credit != '0)       credit <= credit - CW'(1);
    else if (inc && !dec && credit != FULL)     credit <= credit + CW'(1);
  end

  assign avail = (credit != '0);

endmodule

// File: rtl/accum_ctrl.sv
// Sequences DPE partial sums into accumulator rows, spacing same-row issues by
// HAZ cycles and holding the last subset back until downstream credit exists.
module accum_ctrl import accum_pkg::*; #(
  parameter int DATAW   = DATAW_D,
  parameter int DEPTH   = DEPTH_D,
  parameter int ADDRW   = $clog2(DEPTH),
  parameter int SUBW    = SUBW_D,
  parameter int HAZ     = HAZ_D,
  parameter int CREDITS = CREDITS_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [ADDRW-1:0] cfg_nrows,
  input  logic [SUBW-1:0]  cfg_nsub,
  output logic             cfg_err,
  input  logic             i_valid,
  input  logic [DATAW-1:0] i_data,
  output logic             i_ready,
  output logic             acc_valid,
  output logic             acc_accum,
  output logic             acc_last,
  output logic [DATAW-1:0] acc_data,
  output logic [ADDRW-1:0] acc_addr,
  input  logic             res_valid,
  input  logic             credit_ret,
  output logic             busy,
  output logic             done
);

  localparam logic [ADDRW-1:0] HAZ_A = ADDRW'(HAZ);

  state_t           state, state_nxt;
  logic [ADDRW-1:0] nrows, row, gap_cnt, res_cnt;
  logic [SUBW-1:0]  nsub, subset;
  logic             cfg_ok, accept, last_sub, row_wrap, credit_ok, gap_end, res_end;

  assign cfg_ok   = cfg_valid && (cfg_nrows != '0) && (cfg_nsub != '0);
  assign last_sub = (subset == nsub - SUBW'(1));
  assign row_wrap = (row == nrows - ADDRW'(1));
  assign i_ready  = (state == RUN) && (!last_sub || credit_ok);
  assign accept   = i_valid && i_ready;
  assign busy     = (state != IDLE);
  // GAP is only entered with nrows < HAZ, so this never underflows.
  assign gap_end  = (gap_cnt == HAZ_A - nrows - ADDRW'(1));
  assign res_end  = (res_cnt + ADDRW'(res_valid)) >= nrows;

  credit_cnt #(.CREDITS(CREDITS)) u_credit (
    .clk   (clk),
    .rst   (rst),
    .dec   (accept && last_sub),
    .inc   (credit_ret),
    .avail (credit_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cfg_ok) state_nxt = RUN;
      RUN:     if (accept && row_wrap)
                 state_nxt = last_sub ? DRAIN : ((nrows < HAZ_A) ? GAP : RUN);
      GAP:     if (gap_end) state_nxt = RUN;
      DRAIN:   if (res_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nrows     <= '0;
      nsub      <= '0;
      row       <= '0;
      subset    <= '0;
      gap_cnt   <= '0;
      res_cnt   <= '0;
      acc_valid <= 1'b0;
      acc_accum <= 1'b0;
      acc_last  <= 1'b0;
      acc_data  <= '0;
      acc_addr  <= '0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      acc_valid <= accept;
      done      <= (state == DRAIN) && res_end;
      cfg_err   <= (state == IDLE) && cfg_valid && !cfg_ok;
      gap_cnt   <= (state == GAP) ? gap_cnt + ADDRW'(1) : '0;

      if (accept) begin
        acc_data  <= i_data;
        acc_addr  <= row;
        acc_accum <= (subset != '0);
        acc_last  <= last_sub;
        if (row_wrap) begin
          row    <= '0;
          subset <= subset + SUBW'(1);
        end else begin
          row <= row + ADDRW'(1);
        end
      end

      // Results that arrive while idle belong to no vector and are dropped.
      if (state == IDLE) begin
        if (cfg_ok) begin
          nrows   <= cfg_nrows;
          nsub    <= cfg_nsub;
          row     <= '0;
          subset  <= '0;
          res_cnt <= '0;
        end
      end else if (res_valid) begin
        res_cnt <= res_cnt + ADDRW'(1);
      end
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Randomised self-checking bench for accum_ctrl; acts as DPE, accumulator and
// downstream queue, and predicts the issue stream from row/subset arithmetic.
module tb_accum_ctrl;

  localparam int DATAW = 16, DEPTH = 32, ADDRW = 5, SUBW = 4, HAZ = 4, CREDITS = 2;

  logic             clk = 1'b0, rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [ADDRW-1:0] cfg_nrows = '0;
  logic [SUBW-1:0]  cfg_nsub = '0;
  logic             cfg_err;
  logic             i_valid = 1'b0;
  logic [DATAW-1:0] i_data = '0;
  logic             i_ready;
  logic             acc_valid, acc_accum, acc_last;
  logic [DATAW-1:0] acc_data;
  logic [ADDRW-1:0] acc_addr;
  logic             res_valid = 1'b0, credit_ret = 1'b0;
  logic             busy, done;

  accum_ctrl #(.DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .SUBW(SUBW),
               .HAZ(HAZ), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_nrows(cfg_nrows),
    .cfg_nsub(cfg_nsub), .cfg_err(cfg_err), .i_valid(i_valid), .i_data(i_data),
    .i_ready(i_ready), .acc_valid(acc_valid), .acc_accum(acc_accum),
    .acc_last(acc_last), .acc_data(acc_data), .acc_addr(acc_addr),
    .res_valid(res_valid), .credit_ret(credit_ret), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int cyc = 0, n_acc, n_done, n_err, res_pending, res_sent;
  int               acc_cyc[$];
  logic [DATAW-1:0] acc_dat[$];
  int               obs_cyc[$];
  logic [ADDRW-1:0] obs_addr[$];
  logic             obs_accum[$], obs_last[$];
  logic [DATAW-1:0] obs_data[$];

  task automatic clear();
    acc_cyc.delete(); acc_dat.delete(); obs_cyc.delete(); obs_addr.delete();
    obs_accum.delete(); obs_last.delete(); obs_data.delete();
    n_acc = 0; n_done = 0; n_err = 0; res_pending = 0; res_sent = 0;
  endtask

  // One clock: log the beat the DUT takes at this edge, then what it issued.
  task automatic tick();
    if (i_valid && i_ready) begin
      acc_cyc.push_back(cyc); acc_dat.push_back(i_data); n_acc++;
    end
    @(posedge clk); #1;
    cyc++;
    if (acc_valid) begin
      obs_cyc.push_back(cyc); obs_addr.push_back(acc_addr);
      obs_accum.push_back(acc_accum); obs_last.push_back(acc_last);
      obs_data.push_back(acc_data);
      if (acc_last) res_pending++;
    end
    if (done) n_done++;
    if (cfg_err) n_err++;
  endtask

  task automatic drive_cycle(input bit v, input bit ret);
    i_valid = v; i_data = DATAW'($urandom); credit_ret = ret;
    res_valid = (res_pending > 0);
    if (res_valid) begin res_pending--; res_sent++; end
    tick();
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; i_valid = 1'b0; res_valid = 1'b0; credit_ret = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    clear();
  endtask

  task automatic apply_cfg(input int nr, input int ns);
    idle_inputs();
    cfg_valid = 1'b1; cfg_nrows = ADDRW'(nr); cfg_nsub = SUBW'(ns);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    repeat (2) @(posedge clk); #1;
    n_vec++; if ({acc_valid, acc_accum, acc_last} !== 3'b0) begin n_bad++;
      $display("FAIL reset_acc_flags: got %b want 000", {acc_valid, acc_accum, acc_last}); end
    n_vec++; if (acc_data !== '0 || acc_addr !== '0) begin n_bad++;
      $display("FAIL reset_acc_data: got data=%0h addr=%0d want 0/0", acc_data, acc_addr); end
    n_vec++; if ({i_ready, busy, done, cfg_err} !== 4'b0) begin n_bad++;
      $display("FAIL reset_ctrl: got ready/busy/done/err=%b want 0000", {i_ready, busy, done, cfg_err}); end
    rst = 1'b0; clear();
    tick();
    n_vec++; if ({i_ready, busy, acc_valid} !== 3'b0) begin n_bad++;
      $display("FAIL post_reset_idle: got ready/busy/vld=%b want 000", {i_ready, busy, acc_valid}); end
  endtask

  task automatic test_basic();
    do_reset();
    apply_cfg(4, 3);
    for (int k = 0; k < 200 && n_done == 0; k++) drive_cycle(1'b1, 1'b1);
    idle_inputs();
    repeat (3) tick();
    n_vec++; if (n_acc != 12 || obs_addr.size() != 12) begin n_bad++;
      $display("FAIL basic_count: got acc=%0d issued=%0d want 12", n_acc, obs_addr.size()); end
    else for (int i = 0; i < 12; i++) begin
      n_vec++;
      if (int'(obs_addr[i]) != i % 4 || obs_accum[i] !== (i >= 4) ||
          obs_last[i] !== (i >= 8) || obs_data[i] !== acc_dat[i]) begin n_bad++;
        $display("FAIL basic_beat%0d: got addr=%0d accum=%b last=%b data=%0h want %0d/%b/%b/%0h",
                 i, obs_addr[i], obs_accum[i], obs_last[i], obs_data[i], i % 4, i >= 4, i >= 8, acc_dat[i]);
      end
    end
    if (n_acc == 12) begin
      n_vec++; if (acc_cyc[11] - acc_cyc[0] != 11) begin n_bad++;
        $display("FAIL basic_span: got %0d want 11", acc_cyc[11] - acc_cyc[0]); end
    end
    n_vec++; if (n_done != 1 || res_sent != 4) begin n_bad++;
      $display("FAIL basic_done: got done=%0d res=%0d want 1/4", n_done, res_sent); end
  endtask

  task automatic test_gap();
    int exp_off[$];
    int off = 0;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 2; r++) begin exp_off.push_back(off); off++; end
      if (s < 2 && 2 < HAZ) off += HAZ - 2;
    end
    apply_cfg(2, 3);
    for (int k = 0; k < 200 && n_done == 0; k++) drive_cycle(1'b1, 1'b1);
    idle_inputs();
    n_vec++; if (n_acc != 6) begin n_bad++;
      $display("FAIL gap_count: got %0d want 6", n_acc); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++; if (acc_cyc[i] - acc_cyc[0] != exp_off[i]) begin n_bad++;
          $display("FAIL gap_offset%0d: got %0d want %0d", i, acc_cyc[i] - acc_cyc[0], exp_off[i]); end
      end
      n_vec++; if (acc_cyc[5] - acc_cyc[0] + 1 != exp_off[5] + 1) begin n_bad++;
        $display("FAIL gap_span: got %0d want %0d", acc_cyc[5] - acc_cyc[0] + 1, exp_off[5] + 1); end
    end
    n_vec++; if (n_done != 1) begin n_bad++;
      $display("FAIL gap_done: got %0d want 1", n_done); end
  endtask

  task automatic test_credit();
    do_reset();
    apply_cfg(4, 1);
    repeat (10) drive_cycle(1'b1, 1'b0);
    n_vec++; if (n_acc != CREDITS) begin n_bad++;
      $display("FAIL credit_stall: got %0d accepts want %0d", n_acc, CREDITS); end
    n_vec++; if (i_ready !== 1'b0) begin n_bad++;
      $display("FAIL credit_ready: got %b want 0", i_ready); end
    drive_cycle(1'b1, 1'b1);
    repeat (10) drive_cycle(1'b1, 1'b0);
    n_vec++; if (n_acc != CREDITS + 1) begin n_bad++;
      $display("FAIL credit_return: got %0d accepts want %0d", n_acc, CREDITS + 1); end
  endtask

  task automatic test_coincide();
    do_reset();
    apply_cfg(4, 1);
    drive_cycle(1'b1, 1'b1);
    repeat (10) drive_cycle(1'b1, 1'b0);
    n_vec++; if (n_acc != CREDITS + 1) begin n_bad++;
      $display("FAIL coincide_credit: got %0d accepts want %0d", n_acc, CREDITS + 1); end
    do_reset();
    res_valid = 1'b1;
    repeat (3) tick();
    idle_inputs();
    repeat (2) tick();
    n_vec++; if (n_done != 0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL idle_res: got done=%0d busy=%b want 0/0", n_done, busy); end
  endtask

  task automatic test_cfg_err();
    do_reset();
    apply_cfg(3, 0);
    n_vec++; if (n_err != 1 || busy !== 1'b0) begin n_bad++;
      $display("FAIL cfg_nsub0: got err=%0d busy=%b want 1/0", n_err, busy); end
    tick();
    n_vec++; if (n_err != 1) begin n_bad++;
      $display("FAIL cfg_err_pulse: got %0d pulses want 1", n_err); end
    apply_cfg(0, 2);
    n_vec++; if (n_err != 2 || busy !== 1'b0) begin n_bad++;
      $display("FAIL cfg_nrows0: got err=%0d busy=%b want 2/0", n_err, busy); end
    clear();
    apply_cfg(3, 2);
    for (int k = 0; k < 200 && n_done == 0; k++) begin
      cfg_valid = (n_acc < 6); cfg_nrows = ADDRW'(5); cfg_nsub = SUBW'(1);
      drive_cycle(1'b1, 1'b1);
    end
    idle_inputs();
    n_vec++; if (obs_addr.size() != 6 || n_err != 0 || n_done != 1) begin n_bad++;
      $display("FAIL cfg_busy_count: got issued=%0d err=%0d done=%0d want 6/0/1",
               obs_addr.size(), n_err, n_done); end
    else for (int i = 0; i < 6; i++) begin
      n_vec++; if (int'(obs_addr[i]) != i % 3 || obs_last[i] !== (i >= 3)) begin n_bad++;
        $display("FAIL cfg_busy_beat%0d: got addr=%0d last=%b want %0d/%b",
                 i, obs_addr[i], obs_last[i], i % 3, i >= 3); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply_cfg(3, 3);
    for (int k = 0; k < 100 && n_acc < 7; k++) drive_cycle(1'b1, 1'b1);
    idle_inputs();
    rst = 1'b1;
    #2;
    n_vec++; if ({busy, acc_valid, i_ready, done} !== 4'b0 || acc_addr !== '0) begin n_bad++;
      $display("FAIL mid_reset: got busy/vld/rdy/done=%b addr=%0d want 0000/0",
               {busy, acc_valid, i_ready, done}, acc_addr); end
    @(posedge clk); #1;
    rst = 1'b0; clear();
    apply_cfg(4, 1);
    repeat (10) drive_cycle(1'b1, 1'b0);
    n_vec++; if (n_acc != CREDITS || obs_addr.size() != CREDITS) begin n_bad++;
      $display("FAIL mid_reset_credit: got %0d accepts want %0d", n_acc, CREDITS); end
    else begin
      n_vec++; if (obs_addr[0] !== '0 || obs_addr[1] !== ADDRW'(1) || obs_accum[0] !== 1'b0 || obs_last[0] !== 1'b1) begin n_bad++;
        $display("FAIL mid_reset_restart: got addr=%0d,%0d accum=%b last=%b want 0,1/0/1",
                 obs_addr[0], obs_addr[1], obs_accum[0], obs_last[0]); end
    end
  endtask

  task automatic test_random();
    int nr, ns, total, mcr;
    bit lastp, dec;
    do_reset();
    mcr = CREDITS;
    for (int v = 0; v < 8; v++) begin
      nr = $urandom_range(1, 6); ns = $urandom_range(1, 4); total = nr * ns;
      clear();
      apply_cfg(nr, ns);
      for (int k = 0; k < 1500 && n_done == 0; k++) begin
        lastp = (n_acc >= nr * (ns - 1));
        if (n_acc >= total || (lastp && mcr == 0)) begin
          n_vec++; if (i_ready !== 1'b0) begin n_bad++;
            $display("FAIL rand_ready v%0d: got %b want 0 (accepted=%0d credit=%0d)", v, i_ready, n_acc, mcr); end
        end
        i_valid = ($urandom_range(0, 3) != 0); i_data = DATAW'($urandom);
        credit_ret = ($urandom_range(0, 2) == 0);
        res_valid = (res_pending > 0) && ($urandom_range(0, 1) == 1);
        if (res_valid) begin res_pending--; res_sent++; end
        cfg_valid = (n_acc < total) && ($urandom_range(0, 9) == 0);
        cfg_nrows = ADDRW'($urandom_range(0, 7)); cfg_nsub = SUBW'($urandom_range(0, 3));
        dec = i_valid && i_ready && lastp;
        if (dec && !credit_ret) begin if (mcr > 0) mcr--; end
        else if (credit_ret && !dec && mcr < CREDITS) mcr++;
        tick();
      end
      idle_inputs();
      n_vec++; if (n_done != 1 || res_sent != nr || n_err != 0) begin n_bad++;
        $display("FAIL rand_done v%0d: got done=%0d res=%0d err=%0d want 1/%0d/0", v, n_done, res_sent, n_err, nr); end
      n_vec++; if (obs_addr.size() != total || n_acc != total) begin n_bad++;
        $display("FAIL rand_count v%0d: got issued=%0d acc=%0d want %0d", v, obs_addr.size(), n_acc, total); end
      else for (int i = 0; i < total; i++) begin
        n_vec++;
        if (int'(obs_addr[i]) != i % nr || obs_accum[i] !== (i >= nr) ||
            obs_last[i] !== (i / nr == ns - 1) || obs_data[i] !== acc_dat[i] ||
            obs_cyc[i] != acc_cyc[i] + 1 || (i >= nr && obs_cyc[i] - obs_cyc[i - nr] < HAZ)) begin n_bad++;
          $display("FAIL rand_beat v%0d.%0d: got addr=%0d accum=%b last=%b data=%0h lat=%0d want %0d/%b/%b/%0h/1 row-gap>=%0d",
                   v, i, obs_addr[i], obs_accum[i], obs_last[i], obs_data[i], obs_cyc[i] - acc_cyc[i],
                   i % nr, i >= nr, i / nr == ns - 1, acc_dat[i], HAZ);
        end
      end
    end
  endtask

  initial begin
    clear();
    test_reset();
    test_basic();
    test_gap();
    test_credit();
    test_coincide();
    test_cfg_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
